// File: rtl/me_sad_search.sv
// Full-search block-matching motion estimator: scans every +/-RANGE offset of
// a BLKxBLK reference block over its search window and keeps the minimum SAD.
module me_sad_search #(
  parameter  int PIX_W  = 8,
  parameter  int BLK    = 16,
  parameter  int RANGE  = 8,
  localparam int SW     = BLK + 2*RANGE,
  localparam int NPIX   = BLK*BLK,
  localparam int DIST_W = PIX_W + $clog2(NPIX),
  localparam int MV_W   = $clog2(RANGE+1) + 1,
  localparam int RA_W   = $clog2(NPIX),
  localparam int SA_W   = $clog2(SW*SW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_signal,
  input  logic              early_term_en,
  output logic [RA_W-1:0]   address_ref,
  output logic [SA_W-1:0]   address_search,
  input  logic [PIX_W-1:0]  ref_data,
  input  logic [PIX_W-1:0]  search_data,
  output logic [DIST_W-1:0] best_distance,
  output logic [MV_W-1:0]   motion_vector_x,
  output logic [MV_W-1:0]   motion_vector_y,
  output logic              process_completed
);

  localparam int CNT_W = $clog2(BLK);
  localparam int OFF_W = $clog2(2*RANGE+1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  r_reg;
  logic [CNT_W-1:0]  c_reg;
  logic [OFF_W-1:0]  dx_reg;
  logic [OFF_W-1:0]  dy_reg;
  logic [DIST_W-1:0] acc_reg;
  logic [DIST_W-1:0] best_reg;
  logic [MV_W-1:0]   mvx_reg;
  logic [MV_W-1:0]   mvy_reg;
  logic              et_reg;
  logic              abort_reg;
  logic              valid_reg;
  logic              done_reg;

  logic [PIX_W-1:0]  abs_diff;
  logic [DIST_W-1:0] acc_next;
  logic              last_pix;
  logic              last_col;
  logic              et_hit;

  // valid_reg marks that the pixel pair on the data inputs belongs to the
  // current candidate (its address went out during RUN on the previous cycle)
  always_comb begin
    abs_diff = (ref_data >= search_data) ? (ref_data - search_data)
                                         : (search_data - ref_data);
    acc_next = acc_reg + DIST_W'(abs_diff);
  end

  assign last_col = (c_reg == CNT_W'(BLK-1));
  assign last_pix = last_col && (r_reg == CNT_W'(BLK-1));
  assign et_hit   = et_reg && valid_reg && (acc_next >= best_reg);

  assign address_ref    = RA_W'(r_reg) * RA_W'(BLK) + RA_W'(c_reg);
  assign address_search = (SA_W'(dy_reg) + SA_W'(r_reg)) * SA_W'(SW)
                        + SA_W'(dx_reg) + SA_W'(c_reg);

  // Window offset 0..2R maps to signed motion vector -R..+R on each axis
  logic [OFF_W-1:0] off_cur [2];
  logic [MV_W-1:0]  mv_cand [2];

  assign off_cur[0] = dx_reg;
  assign off_cur[1] = dy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mv
      assign mv_cand[gi] = MV_W'(off_cur[gi]) - MV_W'(RANGE);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      r_reg     <= '0;
      c_reg     <= '0;
      dx_reg    <= '0;
      dy_reg    <= '0;
      acc_reg   <= '0;
      best_reg  <= '0;
      mvx_reg   <= '0;
      mvy_reg   <= '0;
      et_reg    <= 1'b0;
      abort_reg <= 1'b0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start_signal) begin
            state_reg <= S_INIT;
            et_reg    <= early_term_en;
            done_reg  <= 1'b0;
          end
        end

        S_INIT: begin
          best_reg  <= '1;
          mvx_reg   <= '0;
          mvy_reg   <= '0;
          r_reg     <= '0;
          c_reg     <= '0;
          dx_reg    <= '0;
          dy_reg    <= '0;
          acc_reg   <= '0;
          valid_reg <= 1'b0;
          abort_reg <= 1'b0;
          state_reg <= S_RUN;
        end

        S_RUN: begin
          valid_reg <= 1'b1;
          if (valid_reg) begin
            acc_reg <= acc_next;
          end
          if (et_hit || last_pix) begin
            r_reg     <= '0;
            c_reg     <= '0;
            abort_reg <= et_hit;
            state_reg <= S_DRAIN;
          end else if (last_col) begin
            c_reg <= '0;
            r_reg <= r_reg + 1'b1;
          end else begin
            c_reg <= c_reg + 1'b1;
          end
        end

        S_DRAIN: begin
          valid_reg <= 1'b0;
          abort_reg <= 1'b0;
          acc_reg   <= '0;
          // Strict compare so that ties keep the earlier raster candidate
          if (!abort_reg && (acc_next < best_reg)) begin
            best_reg <= acc_next;
            mvx_reg  <= mv_cand[0];
            mvy_reg  <= mv_cand[1];
          end
          if (dx_reg == OFF_W'(2*RANGE)) begin
            dx_reg <= '0;
            if (dy_reg == OFF_W'(2*RANGE)) begin
              dy_reg    <= '0;
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              dy_reg    <= dy_reg + 1'b1;
              state_reg <= S_RUN;
            end
          end else begin
            dx_reg    <= dx_reg + 1'b1;
            state_reg <= S_RUN;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign best_distance     = best_reg;
  assign motion_vector_x   = mvx_reg;
  assign motion_vector_y   = mvy_reg;
  assign process_completed = done_reg;

endmodule
